spi_flash_arbiter: RTL and testbench
====================================

Name: spi_flash_arbiter

Overview:
- Shares one MappedSPIFlash read port between two requesters: port I (instruction fetch) and port D (data load).
- Each requester sees the same rstrb / word_address / rdata / rbusy handshake as MappedSPIFlash.
- The block latches requests, arbitrates round-robin, sequences the flash strobe, and returns data to the winner.
- It sits between the femtoRV core bus and the MappedSPIFlash instance.

Parameters:
- ADDR_W, 20, word-address width; matches MappedSPIFlash word_address.
- DATA_W, 32, data width.
- ACK_TIMEOUT, 15, max cycles in WAIT_ACK waiting for flash_rbusy to rise before treating the access as complete.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- i_rstrb  in  1  port I read strobe, one-cycle pulse.
- i_word_address  in  ADDR_W  port I address, valid with i_rstrb.
- i_rdata  out  DATA_W  port I read data.
- i_rbusy  out  1  port I busy.
- d_rstrb  in  1  port D read strobe.
- d_word_address  in  ADDR_W  port D address.
- d_rdata  out  DATA_W  port D read data.
- d_rbusy  out  1  port D busy.
- flash_rstrb  out  1  strobe to MappedSPIFlash.rstrb.
- flash_word_address  out  ADDR_W  to MappedSPIFlash.word_address.
- flash_rdata  in  DATA_W  from MappedSPIFlash.rdata.
- flash_rbusy  in  1  from MappedSPIFlash.rbusy.

Behaviour:
- Reset: all outputs 0, both pending flags 0, state IDLE, last_grant=D so I wins the first tie.
- Reset mid-transfer aborts the sequence; the flash completes its transfer internally and the result is discarded.
- Request capture:
  - x_rstrb with x_rbusy=0 sets pend_x, latches the address, and raises x_rbusy on the next edge.
  - x_rstrb while x_rbusy=1 is ignored; the address is not re-latched.
- States: IDLE -> ISSUE -> WAIT_ACK -> WAIT_DATA -> DONE -> IDLE.
- IDLE:
  - Any pend -> ISSUE.
  - If both are pending, grant the port that is not last_grant.
  - A single pending port wins regardless of last_grant.
- ISSUE: one cycle. flash_rstrb=1, flash_word_address = granted address; go to WAIT_ACK.
- WAIT_ACK:
  - flash_rbusy=1 -> WAIT_DATA.
  - If ACK_TIMEOUT cycles elapse without flash_rbusy, go to DONE and sample flash_rdata (covers a flash that answers within one cycle).
- WAIT_DATA: on flash_rbusy=0 -> DONE.
- DONE:
  - Register flash_rdata into the granted port's rdata, clear its pend and rbusy, update last_grant, go to IDLE.
- Timing:
  - x_rdata is valid in the cycle x_rbusy falls and holds until that port's next completion.
  - Minimum latency from rstrb to rbusy low is 4 + flash busy cycles.
- A strobe on the losing port during a grant is captured and served next.
- Simultaneous strobes on both ports are both captured; I is served first after reset, then ports alternate.
- flash_word_address holds its value outside ISSUE; flash_rstrb is high only in ISSUE.
- Widths are fixed; no arithmetic except the timeout counter, which is clog2(ACK_TIMEOUT+1) bits and saturates.

Optional Feature:
- SPI_FLASH_ARB_CACHE_EN defined:
  - Each port keeps a one-entry cache: tag ADDR_W, data DATA_W, valid bit, all cleared by reset.
  - An accepted strobe whose address matches the valid tag raises rbusy for exactly one cycle, then returns the cached data. No flash access and no grant; last_grant is unchanged.
  - A miss follows the normal path, and DONE fills that port's entry.
- Undefined: every strobe goes to the flash; no cache registers exist.

Decomposition:
- Package spi_flash_arb_pkg:
  - State enum (IDLE, ISSUE, WAIT_ACK, WAIT_DATA, DONE).
  - Port index constants PORT_I=0, PORT_D=1.
  - Default ADDR_W/DATA_W.
- One sub-module, spi_flash_arb_port:
  - Per-port capture, pend flag, rbusy/rdata registers and the optional cache.
  - Instantiated twice; the FSM and grant logic stay in the top.

Test Plan:
- Single I read at 0x00010 with a flash model returning 0xDEADBEEF after 60 busy cycles:
  - flash_rstrb pulses once with address 0x00010.
  - i_rdata = 0xDEADBEEF when i_rbusy falls.
  - d_rbusy stays 0.
- i_rstrb and d_rstrb in the same cycle (addresses 0x00004, 0x00008) after reset:
  - I is granted first, then D.
  - Two flash strobes in that order, each port gets its own word.
- Back-to-back streams on both ports, 8 requests each: grants strictly alternate I, D, I, D…; no request is lost.
- Reset asserted during WAIT_DATA:
  - All outputs 0 immediately.
  - The next i_rstrb at 0x00020 completes correctly after the flash's stale busy clears.
- Repeat d_rstrb while d_rbusy=1 with a different address: ignored; the original address is served and only one flash strobe is issued.
- With SPI_FLASH_ARB_CACHE_EN, i_rstrb 0x00030 twice:
  - The second access has no flash_rstrb, i_rbusy is high for 1 cycle, and the data matches.
  - Then d_rstrb 0x00030 misses and goes to the flash.

Source files
------------

// File: rtl/spi_flash_arb_pkg.sv
// Shared types and constants for the two-port SPI flash read arbiter.
package spi_flash_arb_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 32;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DATA,
        DONE
    } state_t;

endpackage

// File: rtl/spi_flash_arbiter_if.sv
// Bus bundle for the arbiter: two requester ports (I, D) plus the flash side.
// slave is the arbiter's view; master is the surrounding core/flash view.
interface spi_flash_arbiter_if
    import spi_flash_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              i_rstrb;
    logic [ADDR_W-1:0] i_word_address;
    logic [DATA_W-1:0] i_rdata;
    logic              i_rbusy;

    logic              d_rstrb;
    logic [ADDR_W-1:0] d_word_address;
    logic [DATA_W-1:0] d_rdata;
    logic              d_rbusy;

    logic              flash_rstrb;
    logic [ADDR_W-1:0] flash_word_address;
    logic [DATA_W-1:0] flash_rdata;
    logic              flash_rbusy;

    modport slave (
        input  i_rstrb, i_word_address, d_rstrb, d_word_address,
        input  flash_rdata, flash_rbusy,
        output i_rdata, i_rbusy, d_rdata, d_rbusy,
        output flash_rstrb, flash_word_address
    );

    modport master (
        output i_rstrb, i_word_address, d_rstrb, d_word_address,
        output flash_rdata, flash_rbusy,
        input  i_rdata, i_rbusy, d_rdata, d_rbusy,
        input  flash_rstrb, flash_word_address
    );
endinterface

// File: rtl/spi_flash_arb_port.sv
// One requester port: strobe capture, pending flag, rbusy/rdata registers.
// Optional one-entry read cache when SPI_FLASH_ARB_CACHE_EN is defined.
module spi_flash_arb_port
    import spi_flash_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rstrb,
    input  logic [ADDR_W-1:0] word_address,
    input  logic              done,
    input  logic [DATA_W-1:0] fill_data,
    output logic              pend,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] rdata,
    output logic              rbusy
);

    logic accept;
    assign accept = rstrb & ~rbusy;

`ifdef SPI_FLASH_ARB_CACHE_EN
    logic              c_valid;
    logic [ADDR_W-1:0] c_tag;
    logic [DATA_W-1:0] c_data;
    logic              hit_q;
    logic              hit;

    assign hit = c_valid && (c_tag == word_address);

    // Capture / complete requests; a hit is served locally in one busy cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend    <= 1'b0;
            addr    <= '0;
            rdata   <= '0;
            rbusy   <= 1'b0;
            hit_q   <= 1'b0;
            c_valid <= 1'b0;
            c_tag   <= '0;
            c_data  <= '0;
        end else begin
            hit_q <= 1'b0;
            if (accept && hit) begin
                rbusy <= 1'b1;
                hit_q <= 1'b1;
            end else if (accept) begin
                pend  <= 1'b1;
                addr  <= word_address;
                rbusy <= 1'b1;
            end else if (hit_q) begin
                rbusy <= 1'b0;
                rdata <= c_data;
            end else if (done) begin
                pend    <= 1'b0;
                rbusy   <= 1'b0;
                rdata   <= fill_data;
                c_valid <= 1'b1;
                c_tag   <= addr;
                c_data  <= fill_data;
            end
        end
    end
`else
    // Capture a strobe when idle; release the port when the arbiter completes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend  <= 1'b0;
            addr  <= '0;
            rdata <= '0;
            rbusy <= 1'b0;
        end else if (accept) begin
            pend  <= 1'b1;
            addr  <= word_address;
            rbusy <= 1'b1;
        end else if (done) begin
            pend  <= 1'b0;
            rbusy <= 1'b0;
            rdata <= fill_data;
        end
    end
`endif

endmodule

// File: rtl/spi_flash_arbiter.sv
// Round-robin arbiter sharing one MappedSPIFlash read port between an
// instruction port (I) and a data port (D).
// Optional per-port read cache: define SPI_FLASH_ARB_CACHE_EN.
module spi_flash_arbiter
    import spi_flash_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    spi_flash_arbiter_if.slave   bus
);

    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

    logic [1:0]             rstrb_v;
    logic [1:0][ADDR_W-1:0] waddr_v;
    logic [1:0]             done_v;
    logic [1:0]             pend_v;
    logic [1:0][ADDR_W-1:0] addr_v;
    logic [1:0][DATA_W-1:0] rdata_v;
    logic [1:0]             rbusy_v;

    state_t            state;
    logic              grant;
    logic              last_grant;
    logic              nxt_grant;
    logic [TO_W-1:0]   to_cnt;
    logic              flash_rstrb_q;
    logic [ADDR_W-1:0] flash_addr_q;

    assign rstrb_v = {bus.d_rstrb, bus.i_rstrb};
    assign waddr_v = {bus.d_word_address, bus.i_word_address};

    assign done_v[PORT_I] = (state == DONE) && (grant == PORT_I);
    assign done_v[PORT_D] = (state == DONE) && (grant == PORT_D);

    for (genvar p = 0; p < 2; p++) begin : g_port
        spi_flash_arb_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port (
            .clk          (clk),
            .reset        (reset),
            .rstrb        (rstrb_v[p]),
            .word_address (waddr_v[p]),
            .done         (done_v[p]),
            .fill_data    (bus.flash_rdata),
            .pend         (pend_v[p]),
            .addr         (addr_v[p]),
            .rdata        (rdata_v[p]),
            .rbusy        (rbusy_v[p])
        );
    end

    assign bus.i_rdata            = rdata_v[PORT_I];
    assign bus.i_rbusy            = rbusy_v[PORT_I];
    assign bus.d_rdata            = rdata_v[PORT_D];
    assign bus.d_rbusy            = rbusy_v[PORT_D];
    assign bus.flash_rstrb        = flash_rstrb_q;
    assign bus.flash_word_address = flash_addr_q;

    // Tie goes to the port that did not win last; a lone requester always wins.
    always_comb begin
        nxt_grant = PORT_I;
        if (pend_v[PORT_I] && pend_v[PORT_D]) nxt_grant = ~last_grant;
        else if (pend_v[PORT_D])              nxt_grant = PORT_D;
    end

    // Flash access sequencer; strobe and address are registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            grant         <= PORT_I;
            last_grant    <= PORT_D;
            to_cnt        <= '0;
            flash_rstrb_q <= 1'b0;
            flash_addr_q  <= '0;
        end else begin
            case (state)
                IDLE: if (|pend_v) begin
                    grant         <= nxt_grant;
                    flash_rstrb_q <= 1'b1;
                    flash_addr_q  <= addr_v[nxt_grant];
                    state         <= ISSUE;
                end
                ISSUE: begin
                    flash_rstrb_q <= 1'b0;
                    to_cnt        <= '0;
                    state         <= WAIT_ACK;
                end
                // A flash that never raises busy is assumed to have answered already.
                WAIT_ACK: begin
                    if (bus.flash_rbusy)                          state  <= WAIT_DATA;
                    else if (to_cnt == TO_W'(ACK_TIMEOUT - 1))    state  <= DONE;
                    if (to_cnt != TO_W'(ACK_TIMEOUT))             to_cnt <= to_cnt + 1'b1;
                end
                WAIT_DATA: if (!bus.flash_rbusy) state <= DONE;
                DONE: begin
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Scoreboard bench for spi_flash_arbiter with a behavioural flash model.
// Cache scenario runs when SPI_FLASH_ARB_CACHE_EN is defined.
module tb_spi_flash_arbiter;
    import spi_flash_arb_pkg::*;

    localparam int AW = 20;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_flash_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    spi_flash_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACK_TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int n_strobes = 0;
    bit d_busy_seen = 0;

    logic [DW-1:0] exp_i[$];
    logic [DW-1:0] exp_d[$];
    logic [AW-1:0] exp_strb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] fdata(input logic [AW-1:0] a);
        if (a == 20'h00010) return 32'hDEADBEEF;
        return {12'hC0D, a};
    endfunction

    // flash model: busy for lat cycles after a strobe, lat=0 answers at once
    int            lat = 3;
    logic          f_busy = 1'b0;
    int            f_cnt = 0;
    logic [AW-1:0] f_addr = '0;
    logic [DW-1:0] f_rdata = '0;
    assign bus.flash_rbusy = f_busy;
    assign bus.flash_rdata = f_rdata;

    always @(posedge clk) begin
        if (bus.flash_rstrb && !f_busy) begin
            f_addr <= bus.flash_word_address;
            if (lat == 0) f_rdata <= fdata(bus.flash_word_address);
            else begin
                f_busy <= 1'b1;
                f_cnt  <= lat;
            end
        end else if (f_busy) begin
            if (f_cnt == 1) begin
                f_busy  <= 1'b0;
                f_rdata <= fdata(f_addr);
            end
            f_cnt <= f_cnt - 1;
        end
    end

    // monitor: flash strobes and rbusy falling edges pop the scoreboard
    initial begin
        logic prev_i, prev_d;
        prev_i = 1'b0;
        prev_d = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_i = 1'b0;
                prev_d = 1'b0;
            end else begin
                if (bus.d_rbusy) d_busy_seen = 1'b1;
                if (bus.flash_rstrb) begin
                    n_strobes++;
                    if (exp_strb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL strobe_unexpected actual=%0h required=none", bus.flash_word_address);
                    end else check("strobe_addr", bus.flash_word_address, exp_strb.pop_front());
                end
                if (prev_i && !bus.i_rbusy) begin
                    if (exp_i.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL i_done_unexpected actual=%0h required=none", bus.i_rdata);
                    end else check("i_rdata", bus.i_rdata, exp_i.pop_front());
                end
                if (prev_d && !bus.d_rbusy) begin
                    if (exp_d.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL d_done_unexpected actual=%0h required=none", bus.d_rdata);
                    end else check("d_rdata", bus.d_rdata, exp_d.pop_front());
                end
                prev_i = bus.i_rbusy;
                prev_d = bus.d_rbusy;
            end
        end
    end

    task automatic issue(input bit port, input logic [AW-1:0] a);
        @(posedge clk); #1;
        if (port == PORT_D) begin bus.d_rstrb = 1'b1; bus.d_word_address = a; end
        else                begin bus.i_rstrb = 1'b1; bus.i_word_address = a; end
        @(posedge clk); #1;
        if (port == PORT_D) bus.d_rstrb = 1'b0;
        else                bus.i_rstrb = 1'b0;
    endtask

    task automatic issue_both(input logic [AW-1:0] ai, input logic [AW-1:0] ad);
        @(posedge clk); #1;
        bus.i_rstrb = 1'b1; bus.i_word_address = ai;
        bus.d_rstrb = 1'b1; bus.d_word_address = ad;
        @(posedge clk); #1;
        bus.i_rstrb = 1'b0;
        bus.d_rstrb = 1'b0;
    endtask

    task automatic stream(input bit port, input logic [AW-1:0] base);
        int n;
        for (int k = 0; k < 8; k++) begin
            n = 0;
            while (((port == PORT_D) ? bus.d_rbusy : bus.i_rbusy) && n < 200) begin
                @(posedge clk); #1; n++;
            end
            check((port == PORT_D) ? "stream_d_wait" : "stream_i_wait", 64'(n < 200), 64'd1);
            issue(port, base + AW'(k));
        end
    endtask

    task automatic drain(input string name, input int max);
        int n;
        n = 0;
        while ((exp_i.size() != 0 || exp_d.size() != 0 || exp_strb.size() != 0 ||
                bus.i_rbusy || bus.d_rbusy) && n < max) begin
            @(posedge clk); #1; n++;
        end
        check(name, 64'(n < max), 64'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_i_rbusy"}, bus.i_rbusy, 0);
        check({tag, "_d_rbusy"}, bus.d_rbusy, 0);
        check({tag, "_i_rdata"}, bus.i_rdata, 0);
        check({tag, "_d_rdata"}, bus.d_rdata, 0);
        check({tag, "_flash_rstrb"}, bus.flash_rstrb, 0);
        check({tag, "_flash_addr"}, bus.flash_word_address, 0);
    endtask

    initial begin
        int ns, cnt, n;
        reset = 1'b1;
        bus.i_rstrb = 1'b0; bus.i_word_address = '0;
        bus.d_rstrb = 1'b0; bus.d_word_address = '0;
        repeat (2) @(posedge clk);
        #1 check_outputs_zero("reset");
        reset = 1'b0;

        // single I read, long flash busy
        lat = 60;
        d_busy_seen = 1'b0;
        exp_strb.push_back(20'h00010);
        exp_i.push_back(32'hDEADBEEF);
        issue(PORT_I, 20'h00010);
        drain("drain_single", 300);
        check("single_d_rbusy_idle", d_busy_seen, 0);

        // simultaneous strobes after reset: I then D
        do_reset();
        lat = 3;
        exp_strb.push_back(20'h00004);
        exp_strb.push_back(20'h00008);
        exp_i.push_back(fdata(20'h00004));
        exp_d.push_back(fdata(20'h00008));
        issue_both(20'h00004, 20'h00008);
        drain("drain_both", 200);

        // back-to-back streams: grants alternate I, D, I, D
        for (int k = 0; k < 8; k++) begin
            exp_strb.push_back(20'h00100 + AW'(k));
            exp_strb.push_back(20'h00200 + AW'(k));
            exp_i.push_back(fdata(20'h00100 + AW'(k)));
            exp_d.push_back(fdata(20'h00200 + AW'(k)));
        end
        fork
            stream(PORT_I, 20'h00100);
            stream(PORT_D, 20'h00200);
        join
        drain("drain_stream", 500);

        // repeated D strobe while busy is ignored
        ns = n_strobes;
        exp_strb.push_back(20'h00040);
        exp_d.push_back(fdata(20'h00040));
        issue(PORT_D, 20'h00040);
        issue(PORT_D, 20'h00044);
        drain("drain_repeat", 200);
        check("repeat_strobe_count", n_strobes - ns, 1);

        // flash never raises busy: timeout path samples rdata
        lat = 0;
        exp_strb.push_back(20'h00060);
        exp_i.push_back(fdata(20'h00060));
        issue(PORT_I, 20'h00060);
        drain("drain_timeout", 100);

        // reset in WAIT_DATA aborts; next request works once flash goes idle
        lat = 60;
        exp_strb.push_back(20'h00050);
        issue(PORT_I, 20'h00050);
        n = 0;
        while (!bus.flash_rbusy && n < 50) begin @(posedge clk); #1; n++; end
        check("abort_flash_busy_seen", 64'(n < 50), 64'd1);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        #1 check_outputs_zero("midreset");
        @(posedge clk); #1 reset = 1'b0;
        check("abort_strobe_consumed", exp_strb.size(), 0);
        n = 0;
        while (bus.flash_rbusy && n < 200) begin @(posedge clk); #1; n++; end
        check("stale_busy_clear", 64'(n < 200), 64'd1);
        lat = 3;
        exp_strb.push_back(20'h00020);
        exp_i.push_back(fdata(20'h00020));
        issue(PORT_I, 20'h00020);
        drain("drain_after_reset", 200);

`ifdef SPI_FLASH_ARB_CACHE_EN
        // cache: miss, then hit with one busy cycle, then other port misses
        do_reset();
        exp_strb.push_back(20'h00030);
        exp_i.push_back(fdata(20'h00030));
        issue(PORT_I, 20'h00030);
        drain("drain_cache_miss", 200);
        ns = n_strobes;
        exp_i.push_back(fdata(20'h00030));
        issue(PORT_I, 20'h00030);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.i_rbusy) cnt++;
        end
        check("cache_hit_busy_cycles", cnt, 1);
        drain("drain_cache_hit", 50);
        check("cache_hit_no_strobe", n_strobes - ns, 0);
        exp_strb.push_back(20'h00030);
        exp_d.push_back(fdata(20'h00030));
        issue(PORT_D, 20'h00030);
        drain("drain_cache_d_miss", 200);
        check("cache_d_miss_strobe", n_strobes - ns, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
